// File: rtl/apb2axi_tag_directory.sv
// Outstanding-transaction tag directory: allocates tags, queues requests for issue in
// allocation order, records completions and frees tags on release.
module apb2axi_tag_directory #(
   parameter int unsigned TAG_NUM    = 16,
   parameter int unsigned TAG_W      = $clog2(TAG_NUM),
   parameter int unsigned AXI_ADDR_W = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  alloc_valid,
   output logic                  alloc_ready,
   input  logic                  alloc_is_write,
   input  logic [AXI_ADDR_W-1:0] alloc_addr,
   input  logic [7:0]            alloc_len,
   input  logic [2:0]            alloc_size,
   input  logic [1:0]            alloc_burst,
   output logic [TAG_W-1:0]      alloc_tag,
   output logic                  iss_valid,
   input  logic                  iss_ready,
   output logic                  iss_is_write,
   output logic [AXI_ADDR_W-1:0] iss_addr,
   output logic [7:0]            iss_len,
   output logic [2:0]            iss_size,
   output logic [1:0]            iss_burst,
   output logic [TAG_W-1:0]      iss_tag,
   input  logic                  cpl_valid,
   input  logic [TAG_W-1:0]      cpl_tag,
   input  logic [1:0]            cpl_resp,
   input  logic                  cpl_error,
   input  logic [7:0]            cpl_num_beats,
   input  logic                  rel_valid,
   input  logic [TAG_W-1:0]      rel_tag,
   input  logic [TAG_W-1:0]      qry_tag,
   output logic [1:0]            qry_state,
   output logic [1:0]            qry_resp,
   output logic                  qry_error,
   output logic [7:0]            qry_num_beats,
   output logic [TAG_W:0]        free_count,
   output logic                  err_unexp_cpl,
   output logic                  err_bad_rel
);

   localparam int unsigned CNT_W = TAG_W + 1;

   typedef enum logic [1:0] {
      ST_FREE   = 2'd0,
      ST_PEND   = 2'd1,
      ST_ISSUED = 2'd2,
      ST_DONE   = 2'd3
   } ent_state_e;

   typedef struct packed {
      logic                  is_write;
      logic [AXI_ADDR_W-1:0] addr;
      logic [7:0]            len;
      logic [2:0]            size;
      logic [1:0]            burst;
   } req_t;

   typedef struct packed {
      logic [1:0] resp;
      logic       error;
      logic [7:0] num_beats;
   } cpl_t;

   ent_state_e       state_q [TAG_NUM];
   ent_state_e       state_d [TAG_NUM];
   req_t             req_q   [TAG_NUM];
   req_t             req_d   [TAG_NUM];
   cpl_t             cpl_q   [TAG_NUM];
   cpl_t             cpl_d   [TAG_NUM];
   logic [TAG_W-1:0] fifo_q  [TAG_NUM];
   logic [TAG_W-1:0] fifo_d  [TAG_NUM];

   logic [TAG_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [TAG_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] iss_cnt_q, iss_cnt_d;
   logic [CNT_W-1:0] free_cnt_q, free_cnt_d;
   logic             err_unexp_cpl_q, err_unexp_cpl_d;
   logic             err_bad_rel_q, err_bad_rel_d;

   logic             free_any;
   logic [TAG_W-1:0] free_idx;
   logic [TAG_W-1:0] head_tag;
   logic             alloc_fire;
   logic             iss_fire;
   logic             cpl_ok;
   logic             rel_ok;

   function automatic logic [TAG_W-1:0] ptr_inc(input logic [TAG_W-1:0] p);
      return (p == TAG_W'(TAG_NUM - 1)) ? '0 : p + TAG_W'(1);
   endfunction

   // Lowest-index FREE entry, from registered state only.
   always_comb begin
      free_any = 1'b0;
      free_idx = '0;
      for (int i = int'(TAG_NUM) - 1; i >= 0; i--) begin
         if (state_q[i] == ST_FREE) begin
            free_any = 1'b1;
            free_idx = TAG_W'(i);
         end
      end
   end

   assign head_tag   = fifo_q[rd_ptr_q];
   assign alloc_fire = alloc_valid && free_any;
   assign iss_fire   = (iss_cnt_q != '0) && iss_ready;
   assign cpl_ok     = cpl_valid && (state_q[cpl_tag] == ST_ISSUED);
   assign rel_ok     = rel_valid && (state_q[rel_tag] == ST_DONE);

   // All state checks use registered state, so same-cycle events on one tag never chain.
   always_comb begin
      state_d         = state_q;
      req_d           = req_q;
      cpl_d           = cpl_q;
      fifo_d          = fifo_q;
      rd_ptr_d        = rd_ptr_q;
      wr_ptr_d        = wr_ptr_q;
      iss_cnt_d       = iss_cnt_q;
      free_cnt_d      = free_cnt_q;
      err_unexp_cpl_d = cpl_valid && !cpl_ok;
      err_bad_rel_d   = rel_valid && !rel_ok;

      if (alloc_fire) begin
         state_d[free_idx] = ST_PEND;
         req_d[free_idx]   = '{is_write: alloc_is_write, addr: alloc_addr, len: alloc_len,
                               size: alloc_size, burst: alloc_burst};
         fifo_d[wr_ptr_q]  = free_idx;
         wr_ptr_d          = ptr_inc(wr_ptr_q);
      end

      if (iss_fire) begin
         state_d[head_tag] = ST_ISSUED;
         rd_ptr_d          = ptr_inc(rd_ptr_q);
      end

      case ({alloc_fire, iss_fire})
         2'b10:   iss_cnt_d = iss_cnt_q + CNT_W'(1);
         2'b01:   iss_cnt_d = iss_cnt_q - CNT_W'(1);
         default: iss_cnt_d = iss_cnt_q;
      endcase

      if (cpl_ok) begin
         state_d[cpl_tag] = ST_DONE;
         cpl_d[cpl_tag]   = '{resp: cpl_resp, error: cpl_error, num_beats: cpl_num_beats};
      end

      if (rel_ok) begin
         state_d[rel_tag] = ST_FREE;
         cpl_d[rel_tag]   = '0;
      end

      case ({alloc_fire, rel_ok})
         2'b10:   free_cnt_d = free_cnt_q - CNT_W'(1);
         2'b01:   free_cnt_d = free_cnt_q + CNT_W'(1);
         default: free_cnt_d = free_cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(TAG_NUM); i++) begin
            state_q[i] <= ST_FREE;
            req_q[i]   <= '0;
            cpl_q[i]   <= '0;
            fifo_q[i]  <= '0;
         end
         rd_ptr_q        <= '0;
         wr_ptr_q        <= '0;
         iss_cnt_q       <= '0;
         free_cnt_q      <= CNT_W'(TAG_NUM);
         err_unexp_cpl_q <= 1'b0;
         err_bad_rel_q   <= 1'b0;
      end else begin
         state_q         <= state_d;
         req_q           <= req_d;
         cpl_q           <= cpl_d;
         fifo_q          <= fifo_d;
         rd_ptr_q        <= rd_ptr_d;
         wr_ptr_q        <= wr_ptr_d;
         iss_cnt_q       <= iss_cnt_d;
         free_cnt_q      <= free_cnt_d;
         err_unexp_cpl_q <= err_unexp_cpl_d;
         err_bad_rel_q   <= err_bad_rel_d;
      end
   end

   assign alloc_ready   = free_any;
   assign alloc_tag     = free_idx;
   assign iss_valid     = (iss_cnt_q != '0);
   assign iss_tag       = head_tag;
   assign iss_is_write  = req_q[head_tag].is_write;
   assign iss_addr      = req_q[head_tag].addr;
   assign iss_len       = req_q[head_tag].len;
   assign iss_size      = req_q[head_tag].size;
   assign iss_burst     = req_q[head_tag].burst;
   assign qry_state     = 2'(state_q[qry_tag]);
   assign qry_resp      = cpl_q[qry_tag].resp;
   assign qry_error     = cpl_q[qry_tag].error;
   assign qry_num_beats = cpl_q[qry_tag].num_beats;
   assign free_count    = free_cnt_q;
   assign err_unexp_cpl = err_unexp_cpl_q;
   assign err_bad_rel   = err_bad_rel_q;

endmodule

// File: tb/tb_apb2axi_tag_directory.sv
// Directed bench for apb2axi_tag_directory: fill, issue, completion, release ordering,
// error pulses, full-pool release/alloc corner and mid-traffic reset.
module tb_apb2axi_tag_directory;

   localparam int unsigned TAG_NUM    = 16;
   localparam int unsigned TAG_W      = 4;
   localparam int unsigned AXI_ADDR_W = 64;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  alloc_valid, alloc_ready, alloc_is_write;
   logic [AXI_ADDR_W-1:0] alloc_addr;
   logic [7:0]            alloc_len;
   logic [2:0]            alloc_size;
   logic [1:0]            alloc_burst;
   logic [TAG_W-1:0]      alloc_tag;
   logic                  iss_valid, iss_ready, iss_is_write;
   logic [AXI_ADDR_W-1:0] iss_addr;
   logic [7:0]            iss_len;
   logic [2:0]            iss_size;
   logic [1:0]            iss_burst;
   logic [TAG_W-1:0]      iss_tag;
   logic                  cpl_valid, cpl_error;
   logic [TAG_W-1:0]      cpl_tag;
   logic [1:0]            cpl_resp;
   logic [7:0]            cpl_num_beats;
   logic                  rel_valid;
   logic [TAG_W-1:0]      rel_tag, qry_tag;
   logic [1:0]            qry_state, qry_resp;
   logic                  qry_error;
   logic [7:0]            qry_num_beats;
   logic [TAG_W:0]        free_count;
   logic                  err_unexp_cpl, err_bad_rel;

   int n_cmp = 0;
   int n_err = 0;

   apb2axi_tag_directory #(.TAG_NUM(TAG_NUM), .TAG_W(TAG_W), .AXI_ADDR_W(AXI_ADDR_W)) dut (
      .clk(clk), .rst(rst),
      .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_is_write(alloc_is_write),
      .alloc_addr(alloc_addr), .alloc_len(alloc_len), .alloc_size(alloc_size),
      .alloc_burst(alloc_burst), .alloc_tag(alloc_tag),
      .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_is_write(iss_is_write),
      .iss_addr(iss_addr), .iss_len(iss_len), .iss_size(iss_size), .iss_burst(iss_burst),
      .iss_tag(iss_tag),
      .cpl_valid(cpl_valid), .cpl_tag(cpl_tag), .cpl_resp(cpl_resp), .cpl_error(cpl_error),
      .cpl_num_beats(cpl_num_beats),
      .rel_valid(rel_valid), .rel_tag(rel_tag),
      .qry_tag(qry_tag), .qry_state(qry_state), .qry_resp(qry_resp), .qry_error(qry_error),
      .qry_num_beats(qry_num_beats),
      .free_count(free_count), .err_unexp_cpl(err_unexp_cpl), .err_bad_rel(err_bad_rel)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic query(input int t, input logic [1:0] st, input logic [1:0] rs,
                        input logic er, input logic [7:0] nb);
      qry_tag = TAG_W'(t);
      #1;
      chk($sformatf("qry_state[%0d]", t), 64'(qry_state), 64'(st));
      chk($sformatf("qry_resp[%0d]", t), 64'(qry_resp), 64'(rs));
      chk($sformatf("qry_error[%0d]", t), 64'(qry_error), 64'(er));
      chk($sformatf("qry_beats[%0d]", t), 64'(qry_num_beats), 64'(nb));
   endtask

   task automatic complete(input int t, input logic [1:0] rs, input logic er, input logic [7:0] nb);
      cpl_valid = 1'b1; cpl_tag = TAG_W'(t); cpl_resp = rs; cpl_error = er; cpl_num_beats = nb;
      tick();
      cpl_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      alloc_valid = 1'b0; alloc_is_write = 1'b0; alloc_addr = '0; alloc_len = '0;
      alloc_size = '0; alloc_burst = '0;
      iss_ready = 1'b0;
      cpl_valid = 1'b0; cpl_tag = '0; cpl_resp = '0; cpl_error = 1'b0; cpl_num_beats = '0;
      rel_valid = 1'b0; rel_tag = '0; qry_tag = '0;

      // Reset state
      tick(); tick();
      chk("rst_free_count", 64'(free_count), 64'(16));
      chk("rst_alloc_ready", 64'(alloc_ready), 64'(1));
      chk("rst_alloc_tag", 64'(alloc_tag), 64'(0));
      chk("rst_iss_valid", 64'(iss_valid), 64'(0));
      chk("rst_err_unexp", 64'(err_unexp_cpl), 64'(0));
      chk("rst_err_rel", 64'(err_bad_rel), 64'(0));
      query(0, 2'd0, 2'd0, 1'b0, 8'd0);
      rst = 1'b0;

      // Fill all 16 tags with issue stalled
      for (int i = 0; i < 16; i++) begin
         alloc_valid = 1'b1; alloc_is_write = i[0]; alloc_addr = 64'h1000 + 64'(i) * 64'h100;
         alloc_len = 8'(i + 1); alloc_size = 3'd2; alloc_burst = 2'd1;
         #1;
         chk($sformatf("fill_ready[%0d]", i), 64'(alloc_ready), 64'(1));
         chk($sformatf("fill_tag[%0d]", i), 64'(alloc_tag), 64'(i));
         chk($sformatf("fill_iss_valid[%0d]", i), 64'(iss_valid), 64'(i != 0));
         tick();
      end
      alloc_valid = 1'b0;
      chk("full_alloc_ready", 64'(alloc_ready), 64'(0));
      chk("full_free_count", 64'(free_count), 64'(0));
      chk("full_iss_tag", 64'(iss_tag), 64'(0));

      // Completion on PENDING tag 7 is unexpected
      complete(7, 2'd1, 1'b1, 8'd3);
      chk("unexp_pend_pulse", 64'(err_unexp_cpl), 64'(1));
      query(7, 2'd1, 2'd0, 1'b0, 8'd0);
      tick();
      chk("unexp_pend_clear", 64'(err_unexp_cpl), 64'(0));

      // Drain issue queue in order; completion of tag 4 collides with its issue
      iss_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("iss_valid[%0d]", i), 64'(iss_valid), 64'(1));
         chk($sformatf("iss_tag[%0d]", i), 64'(iss_tag), 64'(i));
         chk($sformatf("iss_addr[%0d]", i), iss_addr, 64'h1000 + 64'(i) * 64'h100);
         chk($sformatf("iss_wr[%0d]", i), 64'(iss_is_write), 64'(i % 2));
         chk($sformatf("iss_len[%0d]", i), 64'(iss_len), 64'(i + 1));
         chk($sformatf("iss_err_unexp[%0d]", i), 64'(err_unexp_cpl), 64'(i == 5));
         cpl_valid = (i == 4); cpl_tag = 4'd4; cpl_resp = 2'd0; cpl_error = 1'b0;
         cpl_num_beats = 8'd1;
         tick();
         cpl_valid = 1'b0;
      end
      iss_ready = 1'b0;
      chk("drained_iss_valid", 64'(iss_valid), 64'(0));
      query(4, 2'd2, 2'd0, 1'b0, 8'd0);

      // Release of ISSUED tag 0 is rejected
      rel_valid = 1'b1; rel_tag = 4'd0;
      tick();
      rel_valid = 1'b0;
      chk("bad_rel_pulse", 64'(err_bad_rel), 64'(1));
      query(0, 2'd2, 2'd0, 1'b0, 8'd0);

      // Completions
      complete(3, 2'b10, 1'b1, 8'd8);
      chk("cpl3_no_err", 64'(err_unexp_cpl), 64'(0));
      query(3, 2'd3, 2'd2, 1'b1, 8'd8);
      complete(5, 2'd0, 1'b0, 8'd4);
      complete(2, 2'd1, 1'b0, 8'd2);
      complete(9, 2'd0, 1'b0, 8'd16);

      // Completion and release of tag 10 together: release is bad, entry ends DONE
      cpl_valid = 1'b1; cpl_tag = 4'd10; cpl_resp = 2'd3; cpl_error = 1'b0; cpl_num_beats = 8'd6;
      rel_valid = 1'b1; rel_tag = 4'd10;
      tick();
      cpl_valid = 1'b0; rel_valid = 1'b0;
      chk("cplrel_bad_rel", 64'(err_bad_rel), 64'(1));
      chk("cplrel_no_unexp", 64'(err_unexp_cpl), 64'(0));
      query(10, 2'd3, 2'd3, 1'b0, 8'd6);

      // Release 5 then 2; reallocation picks lowest index first
      rel_valid = 1'b1; rel_tag = 4'd5;
      tick();
      rel_tag = 4'd2;
      chk("rel5_no_err", 64'(err_bad_rel), 64'(0));
      chk("rel5_free_count", 64'(free_count), 64'(1));
      chk("rel5_alloc_tag", 64'(alloc_tag), 64'(5));
      tick();
      rel_valid = 1'b0;
      chk("rel2_free_count", 64'(free_count), 64'(2));
      query(5, 2'd0, 2'd0, 1'b0, 8'd0);
      query(2, 2'd0, 2'd0, 1'b0, 8'd0);

      alloc_valid = 1'b1; alloc_addr = 64'hDEAD_0000; alloc_is_write = 1'b1; alloc_len = 8'd7;
      #1;
      chk("realloc_tag_a", 64'(alloc_tag), 64'(2));
      tick();
      alloc_addr = 64'hBEEF_0000; alloc_is_write = 1'b0; alloc_len = 8'd9;
      chk("realloc_tag_b", 64'(alloc_tag), 64'(5));
      chk("realloc_iss_valid", 64'(iss_valid), 64'(1));
      tick();
      alloc_valid = 1'b0;
      chk("realloc_free_count", 64'(free_count), 64'(0));
      iss_ready = 1'b1;
      chk("order_tag_a", 64'(iss_tag), 64'(2));
      chk("order_addr_a", iss_addr, 64'hDEAD_0000);
      tick();
      chk("order_tag_b", 64'(iss_tag), 64'(5));
      chk("order_addr_b", iss_addr, 64'hBEEF_0000);
      chk("order_len_b", 64'(iss_len), 64'(9));
      tick();
      iss_ready = 1'b0;
      chk("order_drained", 64'(iss_valid), 64'(0));
      query(5, 2'd2, 2'd0, 1'b0, 8'd0);

      // Full pool: release 9 with alloc pending gives no grant that cycle
      alloc_valid = 1'b1; alloc_addr = 64'h9999; alloc_len = 8'd1;
      rel_valid = 1'b1; rel_tag = 4'd9;
      #1;
      chk("corner_ready_before", 64'(alloc_ready), 64'(0));
      tick();
      rel_valid = 1'b0;
      chk("corner_ready_after", 64'(alloc_ready), 64'(1));
      chk("corner_tag_after", 64'(alloc_tag), 64'(9));
      chk("corner_free_one", 64'(free_count), 64'(1));
      chk("corner_iss_idle", 64'(iss_valid), 64'(0));
      tick();
      alloc_valid = 1'b0;
      chk("corner_free_zero", 64'(free_count), 64'(0));
      chk("corner_iss_valid", 64'(iss_valid), 64'(1));
      chk("corner_iss_tag", 64'(iss_tag), 64'(9));
      chk("corner_iss_addr", iss_addr, 64'h9999);
      query(9, 2'd1, 2'd0, 1'b0, 8'd0);

      // Release 3, then release 10 with alloc in the same cycle: count nets to zero
      rel_valid = 1'b1; rel_tag = 4'd3;
      tick();
      chk("net_free_pre", 64'(free_count), 64'(1));
      rel_tag = 4'd10; alloc_valid = 1'b1;
      #1;
      chk("net_grant_tag", 64'(alloc_tag), 64'(3));
      tick();
      rel_valid = 1'b0; alloc_valid = 1'b0;
      chk("net_free_post", 64'(free_count), 64'(1));
      chk("net_next_tag", 64'(alloc_tag), 64'(10));
      query(3, 2'd1, 2'd0, 1'b0, 8'd0);

      // Reset mid-traffic with strobes present in the reset cycles
      rst = 1'b1; alloc_valid = 1'b1; iss_ready = 1'b1;
      cpl_valid = 1'b1; cpl_tag = 4'd0; rel_valid = 1'b1; rel_tag = 4'd1;
      tick(); tick();
      rst = 1'b0; alloc_valid = 1'b0; iss_ready = 1'b0; cpl_valid = 1'b0; rel_valid = 1'b0;
      chk("mrst_free_count", 64'(free_count), 64'(16));
      chk("mrst_alloc_ready", 64'(alloc_ready), 64'(1));
      chk("mrst_alloc_tag", 64'(alloc_tag), 64'(0));
      chk("mrst_iss_valid", 64'(iss_valid), 64'(0));
      chk("mrst_err_unexp", 64'(err_unexp_cpl), 64'(0));
      chk("mrst_err_rel", 64'(err_bad_rel), 64'(0));
      for (int t = 0; t < 16; t++) begin
         qry_tag = TAG_W'(t);
         #1;
         chk($sformatf("mrst_qry_state[%0d]", t), 64'(qry_state), 64'(0));
      end
      tick();
      chk("mrst_err_unexp_after", 64'(err_unexp_cpl), 64'(0));
      chk("mrst_err_rel_after", 64'(err_bad_rel), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
